// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module  : rv32i_types (package)
// Brief   : Shared fetch-entry record and fetch FSM state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rv32i_types;

  localparam int FETCH_XLEN = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_queue.sv
// ============================================================================
// Module  : fetch_queue
// Brief   : Power-of-two FIFO of fetch entries with sync clear and push+pop.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_queue
  import rv32i_types::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  fetch_entry_t           i_data,
  input  logic                   i_pop,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  fetch_entry_t  r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign w_push = i_push && !i_clr;
  assign w_pop  = i_pop && !i_clr && (r_count != '0);

  // Occupancy lives in r_count, so pointers may wrap freely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module  : fetch_unit
// Brief   : PC owner, I-cache request FSM with redirect/discard, fetch queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import rv32i_types::*;
#(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h1eceb000,
  parameter int                IQ_DEPTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [XLEN-1:0]           ufp_addr,
  output logic [3:0]                ufp_rmask,
  input  logic [XLEN-1:0]           ufp_rdata,
  input  logic                      ufp_resp,
  input  logic                      flush_valid,
  input  logic [XLEN-1:0]           flush_pc,
  output logic                      deq_valid,
  input  logic                      deq_ready,
  output logic [XLEN-1:0]           deq_inst,
  output logic [XLEN-1:0]           deq_pc,
  output logic [$clog2(IQ_DEPTH):0] iq_count
);

  localparam int CW = $clog2(IQ_DEPTH) + 1;

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_addr;

  logic            w_deq_fire;
  logic [CW-1:0]   w_occ_after;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;
  fetch_entry_t    w_push_data;
  fetch_entry_t    w_head;

  assign w_deq_fire  = deq_valid && deq_ready;
  assign w_occ_after = iq_count - CW'(w_deq_fire);

  // Request strobe is combinational so a hit sustains one fetch per two cycles.
  assign w_issue   = rst && (r_state == IDLE) && !flush_valid &&
                     (w_occ_after < CW'(IQ_DEPTH));
  assign ufp_rmask = w_issue ? 4'hF : 4'h0;
  assign ufp_addr  = (r_state == IDLE) ? r_pc : r_addr;

  assign w_push      = (r_state == WAIT) && ufp_resp && !flush_valid;
  assign w_pop       = w_deq_fire && !flush_valid;
  assign w_push_data = '{pc: r_addr, inst: ufp_rdata};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
    end else if (flush_valid) begin
      r_pc <= {flush_pc[XLEN-1:2], 2'b00};
      case (r_state)
        WAIT, DISCARD: r_state <= ufp_resp ? IDLE : DISCARD;
        default:       r_state <= IDLE;
      endcase
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_addr  <= r_pc;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (ufp_resp) begin
            r_pc    <= r_pc + XLEN'(4);
            r_state <= IDLE;
          end
        end
        DISCARD: begin
          if (ufp_resp) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  fetch_queue #(
    .DEPTH (IQ_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (flush_valid),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (iq_count)
  );

  assign deq_valid = (iq_count != '0);
  assign deq_inst  = w_head.inst;
  assign deq_pc    = w_head.pc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module  : tb_fetch_unit
// Brief   : Randomized fetch_unit bench with a transaction-level queue model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h1eceb000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ufp_addr;
  logic [3:0]  ufp_rmask;
  logic [31:0] ufp_rdata;
  logic        ufp_resp;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;
  logic [2:0]  iq_count;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (RPC),
    .IQ_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ufp_addr    (ufp_addr),
    .ufp_rmask   (ufp_rmask),
    .ufp_rdata   (ufp_rdata),
    .ufp_resp    (ufp_resp),
    .flush_valid (flush_valid),
    .flush_pc    (flush_pc),
    .deq_valid   (deq_valid),
    .deq_ready   (deq_ready),
    .deq_inst    (deq_inst),
    .deq_pc      (deq_pc),
    .iq_count    (iq_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ref_t;

  // Reference: program order of fetched words plus one outstanding request.
  ref_t        m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_req_addr;
  bit          m_busy;
  bit          m_stale;

  bit          c_pending;
  int          c_wait;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc      = RPC;
    m_busy    = 0;
    m_stale   = 0;
    c_pending = 0;
    c_wait    = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_rmask", 32'(ufp_rmask), 32'h0);
    chk("rst_addr", ufp_addr, RPC);
    chk("rst_deq_valid", 32'(deq_valid), 32'h0);
    chk("rst_iq_count", 32'(iq_count), 32'h0);
  endtask

  task automatic run_cycle(input int deq_pct, input int flush_pct, input int lat_max,
                           input bit fixed_data);
    bit   deq_fire;
    bit   exp_issue;
    ref_t e;
    @(negedge clk);
    rst         = 1'b1;
    flush_valid = ($urandom_range(99) < flush_pct);
    flush_pc    = ($urandom_range(7) == 0) ? 32'hffff_fffd : {20'h1eceb, 12'($urandom)};
    deq_ready   = ($urandom_range(99) < deq_pct);
    ufp_resp    = c_pending && (c_wait == 0);
    ufp_rdata   = fixed_data ? 32'h0000_0013 : $urandom;
    #1;
    deq_fire  = (m_q.size() > 0) && deq_ready;
    exp_issue = !m_busy && !flush_valid && ((m_q.size() - (deq_fire ? 1 : 0)) < DEPTH);

    chk("rmask", 32'(ufp_rmask), exp_issue ? 32'hF : 32'h0);
    if (m_busy) chk("hold_addr", ufp_addr, m_req_addr);
    else        chk("pc_addr", ufp_addr, m_pc);
    chk("deq_valid", 32'(deq_valid), 32'(m_q.size() > 0));
    chk("iq_count", 32'(iq_count), 32'(m_q.size()));
    if (m_q.size() > 0) begin
      chk("deq_pc", deq_pc, m_q[0].pc);
      chk("deq_inst", deq_inst, m_q[0].inst);
    end

    if (flush_valid) begin
      m_q.delete();
      m_pc = flush_pc & 32'hffff_fffc;
      if (m_busy) begin
        if (ufp_resp) begin
          m_busy  = 0;
          m_stale = 0;
        end else begin
          m_stale = 1;
        end
      end
    end else begin
      if (deq_fire) void'(m_q.pop_front());
      if (m_busy && ufp_resp) begin
        if (!m_stale) begin
          e.pc   = m_req_addr;
          e.inst = ufp_rdata;
          m_q.push_back(e);
          m_pc = m_pc + 32'd4;
        end
        m_busy  = 0;
        m_stale = 0;
      end
      if (exp_issue) begin
        m_busy     = 1;
        m_stale    = 0;
        m_req_addr = m_pc;
      end
    end

    if (ufp_resp)          c_pending = 0;
    else if (c_pending)    c_wait--;
    if (ufp_rmask == 4'hF) begin
      c_pending = 1;
      c_wait    = $urandom_range(lat_max - 1);
    end
  endtask

  initial begin
    bit hit;
    rst         = 1'b0;
    ufp_rdata   = '0;
    ufp_resp    = 1'b0;
    flush_valid = 1'b0;
    flush_pc    = '0;
    deq_ready   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();

    // Sequential fetch with 1-cycle hits, continuous consumer.
    repeat (40) run_cycle(100, 0, 1, 1'b1);
    // Consumer stalled: queue fills and requests stop.
    repeat (30) run_cycle(0, 0, 2, 1'b0);
    // A single dequeue admits exactly one more request.
    run_cycle(100, 0, 2, 1'b0);
    repeat (10) run_cycle(0, 0, 2, 1'b0);
    // Random traffic with redirects and variable latency.
    repeat (400) run_cycle(60, 6, 3, 1'b0);
    repeat (200) run_cycle(100, 3, 1, 1'b0);

    // Asynchronous reset while a request is outstanding.
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      run_cycle(50, 0, 3, 1'b0);
      if (m_busy) hit = 1;
    end
    chk("reach_wait", 32'(hit), 32'h1);
    @(posedge clk);
    #2;
    rst         = 1'b0;
    ufp_resp    = 1'b0;
    flush_valid = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();

    repeat (300) run_cycle(70, 5, 3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
